dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the CPU load/store unit and the debug/loader port. Grants one requester per cycle, drives the memory's address, write-data, write-enable and output-enable inputs, and returns registered read data on the next cycle. The CPU has priority. A starvation counter guarantees the debug port a grant within a bounded number of cycles. The block sits between the core/debug logic and the data memory; the memory's own debug bypass stays unused (tied low).

---
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for one data-memory port (CPU or debug).
// master = requester, slave = arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned D_ADDR_W = 12,
  parameter int unsigned DATA_W   = 8
) ();
  logic                req;
  logic                we;
  logic [D_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]   wdata;
  logic                gnt;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU and debug ports.
// CPU has priority; a saturating starvation counter bounds the debug wait.
module dmem_arbiter #(
  parameter int unsigned D_ADDR_W     = 12,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       cpu,
  dmem_arbiter_if.slave       dbg,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_oe,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned      CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;

  logic forced;
  logic cpu_gnt_c;
  logic dbg_gnt_c;
  logic gnt_any;
  logic granted_we;

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    forced    = (starve_cnt_q == LIMIT);
    cpu_gnt_c = 1'b0;
    dbg_gnt_c = 1'b0;
    if (!rst) begin
      if (forced && dbg.req) begin
        dbg_gnt_c = 1'b1;
      end else if (cpu.req) begin
        cpu_gnt_c = 1'b1;
      end else if (dbg.req) begin
        dbg_gnt_c = 1'b1;
      end
    end
  end

  // Memory drive: CPU port is the default source when idle
  always_comb begin
    gnt_any    = cpu_gnt_c | dbg_gnt_c;
    mem_addr   = cpu.addr;
    mem_wdata  = cpu.wdata;
    granted_we = cpu.we;
    if (dbg_gnt_c) begin
      mem_addr   = dbg.addr;
      mem_wdata  = dbg.wdata;
      granted_we = dbg.we;
    end
    mem_we = gnt_any & granted_we;
    mem_oe = gnt_any & ~granted_we;
  end

  // Next-state: starvation counter and read-return registers
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    if (!dbg.req || dbg_gnt_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    if (cpu_gnt_c && !cpu.we) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = mem_rdata;
    end
    if (dbg_gnt_c && !dbg.we) begin
      dbg_rvalid_d = 1'b1;
      dbg_rdata_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu.gnt    = cpu_gnt_c;
  assign dbg.gnt    = dbg_gnt_c;
  assign cpu.rvalid = cpu_rvalid_q;
  assign dbg.rvalid = dbg_rvalid_q;
  assign cpu.rdata  = cpu_rdata_q;
  assign dbg.rdata  = dbg_rdata_q;

  a_one_grant : assert property (@(posedge clk) !(cpu_gnt_c && dbg_gnt_c));
  a_we_oe_excl : assert property (@(posedge clk) !(mem_we && mem_oe));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand sequences
// for starvation and mid-read reset, then random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 8;
  localparam int unsigned LIMIT = 8;
  localparam int          NV    = 15;

  logic          clk;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic          mem_oe;

  dmem_arbiter_if #(.D_ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  dmem_arbiter_if #(.D_ADDR_W(AW), .DATA_W(DW)) dbg_if ();

  dmem_arbiter #(.D_ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu_if),
    .dbg       (dbg_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // Environment memory seen by the DUT
  logic [DW-1:0] env_mem [4096];
  logic          env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 4096; i++) env_mem[i] <= init_val(i);
      env_ready <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_oe && !mem_we) ? env_mem[mem_addr] : 8'h00;

  // Reference model state
  logic [DW-1:0] m_mem [4096];
  int unsigned   m_wait;
  logic          m_cg, m_dg;
  logic          e_crv, e_drv;
  logic [DW-1:0] e_crd, e_drd;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input logic r, input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    rst = r;
    cpu_if.req = cr; cpu_if.we = cw; cpu_if.addr = ca; cpu_if.wdata = cd;
    dbg_if.req = dr; dbg_if.we = dw; dbg_if.addr = da; dbg_if.wdata = dd;
  endtask

  // Let combinational outputs settle and work out who the rules say wins
  task automatic settle();
    #1;
    m_dg = !rst && dbg_if.req && ((m_wait >= LIMIT) || !cpu_if.req);
    m_cg = !rst && cpu_if.req && !m_dg;
  endtask

  // Commit this cycle in the model and move to the next cycle
  task automatic advance();
    if (rst) begin
      m_wait = 0; e_crv = 1'b0; e_drv = 1'b0; e_crd = '0; e_drd = '0;
    end else begin
      e_crv = m_cg && !cpu_if.we;
      e_drv = m_dg && !dbg_if.we;
      if (e_crv) e_crd = m_mem[cpu_if.addr];
      if (e_drv) e_drd = m_mem[dbg_if.addr];
      if (m_cg && cpu_if.we) m_mem[cpu_if.addr] = cpu_if.wdata;
      if (m_dg && dbg_if.we) m_mem[dbg_if.addr] = dbg_if.wdata;
      if (dbg_if.req && !m_dg) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      else m_wait = 0;
    end
    @(negedge clk);
  endtask

  task automatic model_compare();
    logic gwe;
    gwe = m_dg ? dbg_if.we : cpu_if.we;
    chk("rnd_cpu_gnt", 32'(cpu_if.gnt), 32'(m_cg));
    chk("rnd_dbg_gnt", 32'(dbg_if.gnt), 32'(m_dg));
    chk("rnd_mem_we",  32'(mem_we), 32'((m_cg || m_dg) && gwe));
    chk("rnd_mem_oe",  32'(mem_oe), 32'((m_cg || m_dg) && !gwe));
    if (m_cg || m_dg) begin
      chk("rnd_mem_addr", 32'(mem_addr), 32'(m_dg ? dbg_if.addr : cpu_if.addr));
      if (gwe) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(m_dg ? dbg_if.wdata : cpu_if.wdata));
    end
    chk("rnd_cpu_rvalid", 32'(cpu_if.rvalid), 32'(e_crv));
    chk("rnd_cpu_rdata",  32'(cpu_if.rdata),  32'(e_crd));
    chk("rnd_dbg_rvalid", 32'(dbg_if.rvalid), 32'(e_drv));
    chk("rnd_dbg_rdata",  32'(dbg_if.rdata),  32'(e_drd));
  endtask

  typedef struct packed {
    logic          rst;
    logic          c_req, c_we; logic [AW-1:0] c_addr; logic [DW-1:0] c_wd;
    logic          d_req, d_we; logic [AW-1:0] d_addr; logic [DW-1:0] d_wd;
    logic          e_cg, e_dg, e_we, e_oe; logic [AW-1:0] e_addr;
    logic          e_crv; logic [DW-1:0] e_crd;
    logic          e_drv; logic [DW-1:0] e_drd;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(3) == 0) return 12'($urandom);
    return 12'($urandom_range(15));
  endfunction

  logic c_pend, d_pend;

  initial begin
    //          rst   creq  cwe   caddr    cwd    dreq  dwe   daddr    dwd     cg    dg    we    oe    addr     crv   crd    drv   drd
    vecs[0]  = '{1'b1,1'b1,1'b1,12'h200,8'h99, 1'b1,1'b0,12'h010,8'h00, 1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,8'h00,1'b0,8'h00};
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = '{1'b0,1'b1,1'b1,12'h123,8'hA5, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,1'b1,1'b0,12'h123, 1'b0,8'h00,1'b0,8'h00};
    vecs[4]  = '{1'b0,1'b1,1'b0,12'h123,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,1'b0,1'b1,12'h123, 1'b0,8'h00,1'b0,8'h00};
    vecs[5]  = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,12'h000, 1'b1,8'hA5,1'b0,8'h00};
    vecs[6]  = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b1,1'b1,12'hFFF,8'h3C, 1'b0,1'b1,1'b1,1'b0,12'hFFF, 1'b0,8'hA5,1'b0,8'h00};
    vecs[7]  = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,12'hFFF,8'h00, 1'b0,1'b1,1'b0,1'b1,12'hFFF, 1'b0,8'hA5,1'b0,8'h00};
    vecs[8]  = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,8'hA5,1'b1,8'h3C};
    vecs[9]  = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b1,1'b1,12'h050,8'h77, 1'b0,1'b1,1'b1,1'b0,12'h050, 1'b0,8'hA5,1'b0,8'h3C};
    vecs[10] = '{1'b0,1'b1,1'b0,12'h050,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,1'b0,1'b1,12'h050, 1'b0,8'hA5,1'b0,8'h3C};
    vecs[11] = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,12'h000, 1'b1,8'h77,1'b0,8'h3C};
    vecs[12] = '{1'b0,1'b1,1'b0,12'h001,8'h00, 1'b1,1'b0,12'h002,8'h00, 1'b1,1'b0,1'b0,1'b1,12'h001, 1'b0,8'h77,1'b0,8'h3C};
    vecs[13] = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,12'h002,8'h00, 1'b0,1'b1,1'b0,1'b1,12'h002, 1'b1,8'h5B,1'b0,8'h3C};
    vecs[14] = '{1'b0,1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,8'h5B,1'b1,8'h58};

    for (int i = 0; i < 4096; i++) m_mem[i] = init_val(i);
    m_wait = 0; m_cg = 1'b0; m_dg = 1'b0;
    e_crv = 1'b0; e_drv = 1'b0; e_crd = '0; e_drd = '0;
    drive(1'b1, 1'b1, 1'b1, 12'h200, 8'h99, 1'b1, 1'b0, 12'h010, 8'h00);
    @(negedge clk);

    // Directed vector table
    for (int r = 0; r < NV; r++) begin
      drive(vecs[r].rst, vecs[r].c_req, vecs[r].c_we, vecs[r].c_addr, vecs[r].c_wd,
            vecs[r].d_req, vecs[r].d_we, vecs[r].d_addr, vecs[r].d_wd);
      settle();
      chk($sformatf("vec%0d_cpu_gnt", r), 32'(cpu_if.gnt), 32'(vecs[r].e_cg));
      chk($sformatf("vec%0d_dbg_gnt", r), 32'(dbg_if.gnt), 32'(vecs[r].e_dg));
      chk($sformatf("vec%0d_mem_we", r),  32'(mem_we),     32'(vecs[r].e_we));
      chk($sformatf("vec%0d_mem_oe", r),  32'(mem_oe),     32'(vecs[r].e_oe));
      if (vecs[r].e_cg || vecs[r].e_dg)
        chk($sformatf("vec%0d_mem_addr", r), 32'(mem_addr), 32'(vecs[r].e_addr));
      chk($sformatf("vec%0d_cpu_rvalid", r), 32'(cpu_if.rvalid), 32'(vecs[r].e_crv));
      chk($sformatf("vec%0d_cpu_rdata", r),  32'(cpu_if.rdata),  32'(vecs[r].e_crd));
      chk($sformatf("vec%0d_dbg_rvalid", r), 32'(dbg_if.rvalid), 32'(vecs[r].e_drv));
      chk($sformatf("vec%0d_dbg_rdata", r),  32'(dbg_if.rdata),  32'(vecs[r].e_drd));
      advance();
    end

    // Starvation: CPU reads every cycle, debug held from cycle 0
    for (int k = 0; k <= 10; k++) begin
      drive(1'b0, 1'(k <= 9), 1'b0, 12'h100, 8'h00, 1'(k <= 8), 1'b0, 12'h010, 8'h00);
      settle();
      chk($sformatf("starve%0d_cpu_gnt", k), 32'(cpu_if.gnt), 32'(k <= 9 && k != 8));
      chk($sformatf("starve%0d_dbg_gnt", k), 32'(dbg_if.gnt), 32'(k == 8));
      if (k == 8) chk("starve_mem_addr", 32'(mem_addr), 32'h010);
      chk($sformatf("starve%0d_dbg_rvalid", k), 32'(dbg_if.rvalid), 32'(k == 9));
      if (k == 9) chk("starve_dbg_rdata", 32'(dbg_if.rdata), 32'h4A);
      advance();
    end

    // Reset while a CPU read is in flight, with debug building up a wait
    drive(1'b0, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 12'h020, 8'h00);
    settle();
    chk("rmid_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
    advance();
    drive(1'b1, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 12'h020, 8'h00);
    settle();
    chk("rmid_rst_cpu_gnt", 32'(cpu_if.gnt), 32'd0);
    chk("rmid_rst_dbg_gnt", 32'(dbg_if.gnt), 32'd0);
    chk("rmid_rst_mem_oe",  32'(mem_oe), 32'd0);
    chk("rmid_rst_mem_we",  32'(mem_we), 32'd0);
    advance();
    for (int k = 0; k <= 9; k++) begin
      drive(1'b0, 1'b1, 1'b0, 12'h123, 8'h00, 1'(k <= 8), 1'b0, 12'h020, 8'h00);
      settle();
      if (k == 0) begin
        chk("rmid_cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
        chk("rmid_cpu_rdata",  32'(cpu_if.rdata),  32'd0);
        chk("rmid_dbg_rdata",  32'(dbg_if.rdata),  32'd0);
      end
      chk($sformatf("rmid%0d_dbg_gnt", k), 32'(dbg_if.gnt), 32'(k == 8));
      if (k == 9) chk("rmid_dbg_rdata_after", 32'(dbg_if.rdata), 32'h7A);
      advance();
    end

    // Random traffic; requesters hold their request until granted
    c_pend = 1'b0;
    d_pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = 1'b0;
      if (!c_pend && $urandom_range(7) != 0) begin
        c_pend = 1'b1;
        cpu_if.we = 1'($urandom_range(1)); cpu_if.addr = rnd_addr(); cpu_if.wdata = 8'($urandom);
      end
      if (!d_pend && $urandom_range(3) == 0) begin
        d_pend = 1'b1;
        dbg_if.we = 1'($urandom_range(1)); dbg_if.addr = rnd_addr(); dbg_if.wdata = 8'($urandom);
      end
      cpu_if.req = c_pend;
      dbg_if.req = d_pend;
      settle();
      model_compare();
      if (m_cg) c_pend = 1'b0;
      if (m_dg) d_pend = 1'b0;
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
